// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared types, size codes and field-width helper for the L1 data cache
package l1_cache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} cache_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Tag width once the byte offset and set index are removed from the address.
  function automatic int tag_width(input int addr_w, input int setnum);
    return addr_w - 2 - $clog2(setnum);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set age ordering; reports the oldest way of the indexed set
module cache_lru #(
  parameter int SETNUM = 8,
  parameter int WAYS   = 2,
  parameter int IDX_W  = 3,
  parameter int WAY_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic             touch,
  input  logic [WAY_W-1:0] touched_way,
  output logic [WAY_W-1:0] victim_way
);

  generate
    if (WAYS == 1) begin : g_single
      assign victim_way = '0;
    end else begin : g_multi
      logic [WAY_W-1:0] age_q [SETNUM][WAYS];
      logic [WAY_W-1:0] old_age;

      assign old_age = age_q[index][touched_way];

      // Ages stay a permutation of 0..WAYS-1, so exactly one way is oldest.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SETNUM; s++)
            for (int w = 0; w < WAYS; w++)
              age_q[s][w] <= WAY_W'(w);
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touched_way)
              age_q[index][w] <= '0;
            else if (age_q[index][w] < old_age)
              age_q[index][w] <= age_q[index][w] + 1'b1;
          end
        end
      end

      always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++)
          if (age_q[index][w] == WAY_W'(WAYS - 1))
            victim_way = WAY_W'(w);
      end
    end
  endgenerate

endmodule

// File: rtl/l1_dcache_wb.sv
// rtl/l1_dcache_wb.sv - write-back, write-allocate set-associative L1 data cache, one word per line
module l1_dcache_wb
  import l1_cache_pkg::*;
#(
  parameter int SETNUM = 8,
  parameter int WAYS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              store,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int IDX_W = $clog2(SETNUM);
  localparam int TAG_W = tag_width(ADDR_W, SETNUM);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]   valid_q [SETNUM];
  logic [WAYS-1:0]   dirty_q [SETNUM];
  logic [TAG_W-1:0]  tag_q   [SETNUM][WAYS];
  logic [DATA_W-1:0] data_q  [SETNUM][WAYS];

  cache_state_t      state;
  logic [WAY_W-1:0]  vic_q;
  logic [WAY_W-1:0]  hit_way, victim, lru_victim;
  logic              hit, req;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  req_tag;

  assign index   = addr[IDX_W+1:2];
  assign req_tag = addr[ADDR_W-1:IDX_W+2];
  assign req     = load | store;

  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] w,
      input logic [1:0] sz, input logic [1:0] off, input logic uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      SZ_HALF: r = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] wd, input logic [1:0] sz, input logic [1:0] off);
    logic [DATA_W-1:0] r;
    r = old;
    case (sz)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[index][w] && tag_q[index][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  // Lowest-index invalid way wins over the LRU choice.
  always_comb begin
    victim = lru_victim;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[index][w])
        victim = WAY_W'(w);
  end

  cache_lru #(.SETNUM(SETNUM), .WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_lru (
    .clk         (clk),
    .rst         (rst),
    .index       (index),
    .touch       (state == IDLE && req && hit),
    .touched_way (hit_way),
    .victim_way  (lru_victim)
  );

  assign stall = ~rst & ((state != IDLE) | (req & ~hit));
  assign rdata = (!rst && state == IDLE && load && !store && hit)
               ? load_extract(data_q[index][hit_way], size, addr[1:0], unsigned_ld) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vic_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int s = 0; s < SETNUM; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (req) begin
          if (hit) begin
            if (store) dirty_q[index][hit_way] <= 1'b1;
          end else begin
            vic_q   <= victim;
            mem_req <= 1'b1;
            if (valid_q[index][victim] && dirty_q[index][victim]) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[index][victim], index, 2'b00};
              mem_wdata <= data_q[index][victim];
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        WRITEBACK: if (mem_ack) begin
          dirty_q[index][vic_q] <= 1'b0;
          state    <= REFILL;
          mem_we   <= 1'b0;
          mem_addr <= {addr[ADDR_W-1:2], 2'b00};
        end
        REFILL: if (mem_ack) begin
          valid_q[index][vic_q] <= 1'b1;
          dirty_q[index][vic_q] <= 1'b0;
          state   <= IDLE;
          mem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (state == IDLE && store && hit)
      data_q[index][hit_way] <= store_merge(data_q[index][hit_way], wdata, size, addr[1:0]);
    if (state == REFILL && mem_ack) begin
      data_q[index][vic_q] <= mem_rdata;
      tag_q[index][vic_q]  <= req_tag;
    end
  end

endmodule

// File: doc/l1_dcache_wb.md
Name: l1_dcache_wb

Overview:
Parametrised N-way set-associative L1 data cache. Write-back, write-allocate, with per-set LRU replacement, byte/half/word loads and stores, and sign/zero extension. Sits in the MEM stage between the core's load/store path and data memory. Raises stall while a miss performs writeback and refill over a req/ack memory handshake.

Parameters:
SETNUM, 8, number of sets (power of 2, ≥2)
WAYS, 2, associativity (power of 2: 1, 2 or 4)
ADDR_W, 32, address width
DATA_W, 32, line/word width (one word per line)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
load  in  1  load request
store  in  1  store request (wins over load if both high)
size  in  2  00 byte, 01 half, 10 word; 11 treated as word
unsigned_ld  in  1  zero-extend sub-word load when 1, else sign-extend
addr  in  ADDR_W  byte address
wdata  in  DATA_W  store data (low bytes used for sub-word)
rdata  out  DATA_W  load result, combinational on hit
stall  out  1  core must hold request stable while high
mem_req  out  1  memory transaction request
mem_we  out  1  1 = writeback, 0 = refill read
mem_addr  out  ADDR_W  word-aligned line address
mem_wdata  out  DATA_W  victim data on writeback
mem_rdata  in  DATA_W  refill data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - addr[1:0] is the byte offset.
  - Index is addr[1+log2(SETNUM):2].
  - Tag is the remaining upper bits.
  - Half uses addr[1]; word ignores addr[1:0]. Misalignment is not checked.
- Per-way state: valid, dirty, tag, data. Per-set state: age[WAYS] of log2(WAYS) bits each.
- Reset (asynchronous, takes effect immediately):
  - all valid/dirty = 0; age[w] = w; FSM = IDLE.
  - Outputs: mem_req = 0, mem_we = 0, stall = 0, rdata = 0.
  - Reset mid-WRITEBACK/REFILL aborts the transaction; any late mem_ack is ignored.
- Hit: valid & tag match in the indexed set.
  - Load hit: rdata is valid the same cycle, stall = 0. Byte/half is extracted at the offset and extended per unsigned_ld. rdata = 0 when no load is hitting.
  - Store hit: at the clock edge, byte/half/word is merged into the line at the offset and dirty = 1.
  - Any hit updates age at the edge: hit way age → 0; ways whose age < old age increment; others unchanged. WAYS = 1 has no age state.
- FSM: IDLE, WRITEBACK, REFILL.
  - IDLE, (load|store) & miss:
    - stall = 1 combinationally.
    - Victim = lowest-index invalid way, else the way with age = WAYS-1; latched at the edge.
    - Next state is WRITEBACK if the victim is valid & dirty, else REFILL.
  - WRITEBACK:
    - mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim data.
    - All held stable until mem_ack. On ack edge: victim dirty = 0, → REFILL.
  - REFILL:
    - mem_req = 1, mem_we = 0, mem_addr = {addr[ADDR_W-1:2], 2'b00}.
    - On ack edge: victim data = mem_rdata, tag = request tag, valid = 1, dirty = 0, → IDLE.
  - stall is 1 in WRITEBACK and REFILL. After REFILL the next cycle re-evaluates in IDLE as a hit, so a store is merged there and age is updated there.
  - mem_req drops the cycle after ack (no back-to-back requests without passing through the FSM).
- Minimum miss cost:
  - Clean miss: stall high from the request cycle through the ack cycle.
  - Dirty miss: two memory transactions.
- mem_ack outside WRITEBACK/REFILL is ignored.

Decomposition:
- Package l1_cache_pkg holds:
  - typedef enum cache_state_t {IDLE, WRITEBACK, REFILL};
  - size constants SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - an index/tag width helper function.
- One sub-module, cache_lru: per-set age array with inputs (index, touch, touched_way) and output victim_way (invalid-first selection done in the parent).
- Load extract and store merge stay as functions inside the top module.

Test Plan:
Defaults: SETNUM=8, WAYS=2. Addresses 0x10, 0x30 and 0x50 all map to set 4.
1. Cold load byte unsigned at 0x10; memory returns 0x123456F0 with ack 3 cycles after mem_req → mem_we=0, mem_addr=0x10, stall released the cycle after ack, rdata=0x000000F0; repeat with signed load → 0xFFFFFFF0, no mem_req.
2. Store half 0xBEEF at 0x12 (hit) → no mem_req; word load at 0x10 → 0xBEEF56F0.
3. Load 0x30 (clean refill 0xAAAA0000), then load 0x50 → WRITEBACK with mem_addr=0x10, mem_wdata=0xBEEF56F0, then REFILL mem_addr=0x50.
4. After fills at 0x10 and 0x30, re-load 0x10, then load 0x50 → victim is 0x30's way, clean, no writeback; a following load of 0x10 hits.
5. Assert rst during REFILL with mem_ack pending → mem_req and stall drop immediately, late ack ignored, next load 0x10 misses.
6. Hold mem_ack low 10 cycles in WRITEBACK → mem_req, mem_addr and mem_wdata stable throughout; simultaneous load+store on a hit → store applied, no load data.
